// File: rtl/border_sprite.sv
// border_sprite: battle-box border ring overlay with edges that track a per-state target rectangle.
// BORDER_ANIM_EN: edges slide 1 px per step_tick; otherwise they snap to the target each cycle.
module border_sprite #(
    parameter int THICK    = 4,
    parameter int STEP_DIV = 100000,
    parameter int FIGHT_L  = 220,
    parameter int FIGHT_R  = 420,
    parameter int FIGHT_T  = 240,
    parameter int FIGHT_B  = 400,
    parameter int TALK_L   = 40,
    parameter int TALK_R   = 500,
    parameter int TALK_T   = 240,
    parameter int TALK_B   = 400
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [1:0] state,
    output logic       sprite_on,
    output logic [8:0] left_border,
    output logic [8:0] right_border,
    output logic [8:0] top_border,
    output logic [8:0] bottom_border
);
    localparam logic [8:0] FL = 9'(FIGHT_L);
    localparam logic [8:0] FR = 9'(FIGHT_R);
    localparam logic [8:0] FT = 9'(FIGHT_T);
    localparam logic [8:0] FB = 9'(FIGHT_B);
    localparam logic [8:0] TL = 9'(TALK_L);
    localparam logic [8:0] TR = 9'(TALK_R);
    localparam logic [8:0] TT = 9'(TALK_T);
    localparam logic [8:0] TB = 9'(TALK_B);
    localparam logic [9:0] TH = 10'(THICK);

    logic       fight, talk;
    logic [8:0] tgt_l, tgt_r, tgt_t, tgt_b;
    logic [8:0] nxt_l, nxt_r, nxt_t, nxt_b;
    logic       outer, inner;

    // Menu and reserved states target the current edges, which freezes the box.
    always_comb begin
        fight = state == 2'b01;
        talk  = state == 2'b10;
        tgt_l = fight ? FL : talk ? TL : left_border;
        tgt_r = fight ? FR : talk ? TR : right_border;
        tgt_t = fight ? FT : talk ? TT : top_border;
        tgt_b = fight ? FB : talk ? TB : bottom_border;
    end

`ifdef BORDER_ANIM_EN
    logic [20:0] cnt;
    logic        step_tick;

    function automatic logic [8:0] step(input logic [8:0] c, input logic [8:0] t);
        return (c < t) ? c + 9'd1 : (c > t) ? c - 9'd1 : c;
    endfunction

    assign step_tick = cnt == 21'(STEP_DIV - 1);

    always_ff @(posedge clk or posedge reset)
        if (reset)
            cnt <= '0;
        else
            cnt <= step_tick ? '0 : cnt + 21'd1;

    always_comb begin
        nxt_l = step_tick ? step(left_border, tgt_l) : left_border;
        nxt_r = step_tick ? step(right_border, tgt_r) : right_border;
        nxt_t = step_tick ? step(top_border, tgt_t) : top_border;
        nxt_b = step_tick ? step(bottom_border, tgt_b) : bottom_border;
    end
`else
    always_comb begin
        nxt_l = tgt_l;
        nxt_r = tgt_r;
        nxt_t = tgt_t;
        nxt_b = tgt_b;
    end
`endif

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            left_border   <= FL;
            right_border  <= FR;
            top_border    <= FT;
            bottom_border <= FB;
        end else begin
            left_border   <= nxt_l;
            right_border  <= nxt_r;
            top_border    <= nxt_t;
            bottom_border <= nxt_b;
        end

    // Widened to 10 bits so R+THICK never wraps against 640-wide x.
    always_comb begin
        outer = (x >= {1'b0, left_border} - TH) && (x < {1'b0, right_border} + TH) &&
                (y >= {1'b0, top_border} - TH) && (y < {1'b0, bottom_border} + TH);
        inner = (x >= {1'b0, left_border}) && (x < {1'b0, right_border}) &&
                (y >= {1'b0, top_border}) && (y < {1'b0, bottom_border});
    end

    always_ff @(posedge clk or posedge reset)
        if (reset)
            sprite_on <= 1'b0;
        else
            sprite_on <= outer && !inner && (state != 2'b00);
endmodule

// File: tb/tb_border_sprite.sv
// tb_border_sprite: scoreboard bench for border_sprite; covers the slide path when BORDER_ANIM_EN is defined.
module tb_border_sprite;
    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] x, y;
    logic [1:0] state;
    logic       sprite_on;
    logic [8:0] left_border, right_border, top_border, bottom_border;
    int         checks = 0;
    int         errors = 0;
    logic       exp_q[$];

    border_sprite #(.STEP_DIV(4)) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .state(state),
        .sprite_on(sprite_on), .left_border(left_border), .right_border(right_border),
        .top_border(top_border), .bottom_border(bottom_border)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] box(input int l, r, t, b);
        return {9'(l), 9'(r), 9'(t), 9'(b)};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pix(input string tag, input int px, py, input logic e);
        x = 10'(px);
        y = 10'(py);
        exp_q.push_back(e);
        cyc(1);
        check(tag, {35'd0, sprite_on}, {35'd0, exp_q.pop_front()});
    endtask

    task automatic restart(input logic [1:0] s);
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        state = s;
    endtask

    initial begin
        reset = 1'b1;
        state = 2'b01;
        x = '0;
        y = '0;
        #1;
        check("rst_sprite", {35'd0, sprite_on}, 36'd0);
        check("rst_edges", {left_border, right_border, top_border, bottom_border}, box(220, 420, 240, 400));
        restart(2'b01);
        pix("ring_l_outer", 216, 300, 1'b1);
        pix("inside_l", 220, 300, 1'b0);
        pix("outside_l", 215, 300, 1'b0);
        pix("inside_r", 419, 300, 1'b0);
        pix("ring_r_outer", 423, 300, 1'b1);
        pix("outside_r", 424, 300, 1'b0);
        pix("ring_t", 300, 236, 1'b1);
        pix("outside_t", 300, 235, 1'b0);
        pix("ring_b", 300, 403, 1'b1);
        pix("outside_b", 300, 404, 1'b0);
        check("fight_edges", {left_border, right_border, top_border, bottom_border}, box(220, 420, 240, 400));
        state = 2'b00;
        pix("menu_off", 216, 300, 1'b0);
`ifdef BORDER_ANIM_EN
        restart(2'b10);
        cyc(3);
        check("before_tick", {left_border, right_border, top_border, bottom_border}, box(220, 420, 240, 400));
        cyc(1);
        check("first_tick", {left_border, right_border, top_border, bottom_border}, box(219, 421, 240, 400));
        cyc(36);
        check("step10", {left_border, right_border, top_border, bottom_border}, box(210, 430, 240, 400));
        cyc(320);
        check("mid_slide", {left_border, right_border, top_border, bottom_border}, box(130, 500, 240, 400));
        state = 2'b01;
        cyc(4);
        check("retarget", {left_border, right_border, top_border, bottom_border}, box(131, 499, 240, 400));
        cyc(36);
        check("return", {left_border, right_border, top_border, bottom_border}, box(140, 490, 240, 400));
        state = 2'b00;
        cyc(1000);
        check("menu_hold", {left_border, right_border, top_border, bottom_border}, box(140, 490, 240, 400));
        pix("menu_ring_off", 136, 300, 1'b0);
        restart(2'b10);
        cyc(720);
        check("talk_done", {left_border, right_border, top_border, bottom_border}, box(40, 500, 240, 400));
        cyc(80);
        check("talk_stay", {left_border, right_border, top_border, bottom_border}, box(40, 500, 240, 400));
        pix("talk_ring", 36, 300, 1'b1);
        restart(2'b10);
        cyc(50);
        reset = 1'b1;
        #1;
        check("async_rst", {left_border, right_border, top_border, bottom_border}, box(220, 420, 240, 400));
        check("async_rst_sp", {35'd0, sprite_on}, 36'd0);
`else
        restart(2'b10);
        cyc(1);
        check("snap_talk", {left_border, right_border, top_border, bottom_border}, box(40, 500, 240, 400));
        pix("talk_ring", 36, 300, 1'b1);
        pix("talk_inside", 40, 300, 1'b0);
        state = 2'b00;
        cyc(1000);
        check("menu_hold", {left_border, right_border, top_border, bottom_border}, box(40, 500, 240, 400));
        state = 2'b11;
        cyc(5);
        check("rsv_hold", {left_border, right_border, top_border, bottom_border}, box(40, 500, 240, 400));
        state = 2'b01;
        cyc(1);
        check("snap_fight", {left_border, right_border, top_border, bottom_border}, box(220, 420, 240, 400));
        state = 2'b10;
        cyc(1);
        x = 10'd36;
        y = 10'd300;
        cyc(1);
        reset = 1'b1;
        #1;
        check("async_rst", {left_border, right_border, top_border, bottom_border}, box(220, 420, 240, 400));
        check("async_rst_sp", {35'd0, sprite_on}, 36'd0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/border_sprite.md
Name: border_sprite

Overview:
- Generates the white battle-box border overlay for the VGA pixel pipeline.
- Keeps four box edges (left/right/top/bottom) that slide toward a per-game-state target rectangle.
- Asserts sprite_on when the current scan pixel (x, y) lies on the border ring.
- Exports the live edges so the bullet and player logic can clamp to the box interior.

Parameters:
- THICK, 4: border ring thickness in pixels, drawn outside the box edges.
- STEP_DIV, 100000: clk cycles per animation step (1 ms at 100 MHz); legal range 1..2^20.
- FIGHT_L/R/T/B, 220/420/240/400: target edges when state = 01.
- TALK_L/R/T/B, 40/500/240/400: target edges when state = 10.

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  asynchronous, active-high reset.
- x  in  10  current pixel column, 0..639.
- y  in  10  current pixel row, 0..479.
- state  in  2  game state: 00 menu, 01 fight, 10 dialogue, 11 reserved.
- sprite_on  out  1  pixel is on the border ring; registered.
- left_border  out  9  current left edge.
- right_border  out  9  current right edge.
- top_border  out  9  current top edge.
- bottom_border  out  9  current bottom edge.

Behaviour:
- Reset values: edges = FIGHT_L/R/T/B (220/420/240/400); step counter = 0; sprite_on = 0.
- Step counter:
  - Counts 0..STEP_DIV-1 and wraps.
  - step_tick is high for one cycle when the count is STEP_DIV-1.
  - STEP_DIV = 1 means step_tick is high every cycle.
- Target selection:
  - 01 selects the FIGHT set; 10 selects the TALK set.
  - 00 and 11: target = current edges, so the edges freeze.
- On step_tick, each edge independently moves 1 toward its target: +1 if below, -1 if above, unchanged if equal.
- All edges are registered outputs. No overshoot; an edge stops exactly on its target.
- A state change mid-slide retargets on the next step_tick. Motion continues from the current position, with no jump.
- Edge arithmetic is unsigned 9-bit. Targets must satisfy L >= THICK, T >= THICK, L < R, T < B, R+THICK <= 511, B+THICK <= 511. Edges therefore never wrap.
- Ring test, using the current registered edges and comparisons widened to 10 bits:
  - outer = (x >= L-THICK) && (x < R+THICK) && (y >= T-THICK) && (y < B+THICK).
  - inner = (x >= L) && (x < R) && (y >= T) && (y < B).
  - ring = outer && !inner.
- sprite_on <= ring && (state != 00). This gives 1-cycle latency from x/y to sprite_on.
- State 00 forces sprite_on to 0 on the next cycle. Edges are retained.
- Reset asserted mid-slide immediately restores the reset edges and clears sprite_on and the counter.

Optional Feature:
- Macro: BORDER_ANIM_EN.
- Defined: edges slide 1 px per step_tick as described.
- Undefined:
  - The step counter is removed.
  - Each cycle, every edge loads its target directly (1-cycle snap to the new rectangle).
  - Retargeting for 00/11 still freezes the edges.

Test Plan:
- Reset, state=01, x=216,y=300 -> sprite_on=1 one cycle later; edges read 220/420/240/400.
- Pixels x=220,y=300 (inside) and x=215,y=300 (outside ring) -> sprite_on=0 for both; x=419,y=300 -> 0; x=423,y=300 -> 1; x=424,y=300 -> 0.
- STEP_DIV=4, BORDER_ANIM_EN defined, state 01->10:
  - left_border decrements 1 every 4 cycles and reaches 40 after 180 steps (720 cycles).
  - right_border reaches 500 after 80 steps and stays.
  - Top and bottom stay unchanged.
- State 00 with x=216,y=300 -> sprite_on=0; edges hold their value over 1000 cycles.
- Mid-slide (left=130) switch 10->01 -> left increments back toward 220 from 130, with no discontinuity.
- Assert reset mid-slide -> edges return to 220/420/240/400 asynchronously and sprite_on=0. Without BORDER_ANIM_EN, state 01->10 gives edges 40/500/240/400 one cycle later.
